// File: rtl/a2d_conv_sched_if.sv
// Handshake between the conversion scheduler and the A2D SPI interface block.
interface a2d_conv_sched_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/a2d_conv_sched.sv
// Round-robin A2D conversion scheduler with background channel scan and
// a watchdog that aborts conversions whose completion never arrives.
module a2d_conv_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned TMO_CYC  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]   done_pls,
  output logic [11:0]          rd_data,
  output logic                 tmo_err,
  output logic                 busy,
  input  logic                 scan_en,
  input  logic [7:0]           scan_mask,
  output logic [95:0]          scan_res,
  output logic [7:0]           scan_vld,
  a2d_conv_sched_if.master     a2d
);

  localparam int unsigned TW = $clog2(TMO_CYC);
  localparam int unsigned SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  owner, rr_ptr, scan_ptr, chnnl_q;
  logic        own_scan, aborted, scan_pend;
  logic [11:0] res_q;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] scan_cnt;

  logic        req_hit, req_hi, scan_lo, scan_hi, scan_take, tmo_hit, slot_hit;
  logic [2:0]  req_sel, req_ch, scan_ch;

  assign tmo_hit  = (tmo_cnt == TW'(TMO_CYC - 1));
  assign slot_hit = scan_en && (scan_cnt == SW'(SCAN_DIV - 1));

  // First pass finds the lowest set bit (wrap case); second pass overrides it
  // with the lowest set bit at/after the pointer when one exists.
  always_comb begin
    req_hit = 1'b0;
    req_hi  = 1'b0;
    req_sel = '0;
    req_ch  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++)
      if (req[j] && !req_hit) begin
        req_hit = 1'b1;
        req_sel = 3'(j);
      end
    for (int unsigned j = 0; j < NUM_REQ; j++)
      if (req[j] && (3'(j) >= rr_ptr) && !req_hi) begin
        req_hi  = 1'b1;
        req_sel = 3'(j);
      end
    for (int unsigned j = 0; j < NUM_REQ; j++)
      if (3'(j) == req_sel) req_ch = req_chnnl[3*j +: 3];
  end

  always_comb begin
    scan_lo = 1'b0;
    scan_hi = 1'b0;
    scan_ch = '0;
    for (int unsigned j = 0; j < 8; j++)
      if (scan_mask[j] && !scan_lo) begin
        scan_lo = 1'b1;
        scan_ch = 3'(j);
      end
    for (int unsigned j = 0; j < 8; j++)
      if (scan_mask[j] && (3'(j) > scan_ptr) && !scan_hi) begin
        scan_hi = 1'b1;
        scan_ch = 3'(j);
      end
  end

  always_comb begin
    state_d   = state_q;
    scan_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hit) begin
          state_d = ISSUE;
        end else if (scan_pend && (scan_mask != '0)) begin
          state_d   = ISSUE;
          scan_take = 1'b1;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (a2d.cnv_cmplt || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      rr_ptr    <= '0;
      scan_ptr  <= 3'd7;
      chnnl_q   <= '0;
      own_scan  <= 1'b0;
      aborted   <= 1'b0;
      scan_pend <= 1'b0;
      res_q     <= '0;
      rd_data   <= '0;
      tmo_cnt   <= '0;
      scan_cnt  <= '0;
      scan_res  <= '0;
      scan_vld  <= '0;
    end else begin
      if (!scan_en || slot_hit) scan_cnt <= '0;
      else                      scan_cnt <= scan_cnt + 1'b1;

      // A slot expiring in the same cycle it is consumed leaves a new one pending.
      if (slot_hit)       scan_pend <= 1'b1;
      else if (scan_take) scan_pend <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req_hit) begin
            owner    <= req_sel;
            own_scan <= 1'b0;
            chnnl_q  <= req_ch;
          end else if (scan_take) begin
            own_scan <= 1'b1;
            chnnl_q  <= scan_ch;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          aborted <= 1'b0;
        end
        WAIT: begin
          if (a2d.cnv_cmplt) begin
            res_q <= a2d.res;
            if (!own_scan) rd_data <= a2d.res;
          end else if (tmo_hit) begin
            aborted <= 1'b1;
            if (!own_scan) rd_data <= 12'hFFF;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          if (own_scan) begin
            scan_ptr <= chnnl_q;
            for (int unsigned c = 0; c < 8; c++)
              if (chnnl_q == 3'(c)) begin
                if (aborted) begin
                  scan_vld[c] <= 1'b0;
                end else begin
                  scan_vld[c]          <= 1'b1;
                  scan_res[12*c +: 12] <= res_q;
                end
              end
          end else begin
            rr_ptr <= (owner == 3'(NUM_REQ - 1)) ? '0 : owner + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done_pls = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++)
      done_pls[j] = (state_q == DONE) && !own_scan && (owner == 3'(j));
  end

  assign tmo_err      = (state_q == DONE) && aborted;
  assign busy         = (state_q != IDLE);
  assign a2d.strt_cnv = (state_q == ISSUE);
  assign a2d.chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Scoreboard bench for a2d_conv_sched: expected grants/completions are queued
// with the stimulus and consumed by a negedge monitor as the DUT produces them.
module tb_a2d_conv_sched;
  localparam int unsigned NR = 4;
  localparam int unsigned SD = 16;
  localparam int unsigned TC = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [3*NR-1:0] req_chnnl = '0;
  logic [NR-1:0] done_pls;
  logic [11:0]   rd_data;
  logic          tmo_err, busy;
  logic          scan_en = 1'b0;
  logic [7:0]    scan_mask = '0;
  logic [95:0]   scan_res;
  logic [7:0]    scan_vld;

  a2d_conv_sched_if a2d();

  a2d_conv_sched #(.NUM_REQ(NR), .SCAN_DIV(SD), .TMO_CYC(TC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_chnnl(req_chnnl),
    .done_pls(done_pls), .rd_data(rd_data), .tmo_err(tmo_err), .busy(busy),
    .scan_en(scan_en), .scan_mask(scan_mask), .scan_res(scan_res),
    .scan_vld(scan_vld), .a2d(a2d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] pls;
    logic [11:0]   rd;
    logic          tmo;
    logic          rd_chk;
  } done_t;

  int           checks = 0;
  int           errors = 0;
  logic [2:0]   exp_ch[$];
  done_t        exp_done[$];
  longint       strt_t[$];
  int           n_strt = 0;
  logic [NR-1:0] drop_mask = '0;

  // A2D model: lat==0 means cnv_cmplt never comes
  int           lat = 20;
  bit           fixed_res = 1'b1;
  int           m_cnt = 0;
  logic [2:0]   m_ch = '0;

  initial begin
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = '0;
    forever begin
      @(posedge clk); #1;
      a2d.cnv_cmplt = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          a2d.cnv_cmplt = 1'b1;
          a2d.res       = fixed_res ? 12'hA5C : {5'd0, m_ch, 4'd0};
        end
      end
      if (a2d.strt_cnv === 1'b1) begin
        m_cnt = lat;
        m_ch  = a2d.chnnl;
      end
    end
  end

  // Requesters drop req on the edge that ends their done_pls cycle
  initial forever begin
    @(posedge clk); #1;
    req       = req & ~drop_mask;
    drop_mask = '0;
  end

  initial forever begin
    @(negedge clk);
    if (a2d.strt_cnv !== 1'b0) begin
      n_strt++;
      strt_t.push_back($time);
      checks++;
      if (exp_ch.size() == 0) begin
        errors++;
        $display("FAIL strt_unexpected got chnnl=%0d expected no strt_cnv", a2d.chnnl);
      end else begin
        logic [2:0] e;
        e = exp_ch.pop_front();
        if (a2d.chnnl !== e) begin
          errors++;
          $display("FAIL strt_chnnl got %0d expected %0d", a2d.chnnl, e);
        end
      end
    end
    if (done_pls !== '0 || tmo_err !== 1'b0) begin
      drop_mask = drop_mask | done_pls;
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got done_pls=%b tmo_err=%b expected none", done_pls, tmo_err);
      end else begin
        done_t d;
        d = exp_done.pop_front();
        if (done_pls !== d.pls || tmo_err !== d.tmo || (d.rd_chk && rd_data !== d.rd)) begin
          errors++;
          $display("FAIL done_result got pls=%b rd=%h tmo=%b expected pls=%b rd=%h tmo=%b",
                   done_pls, rd_data, tmo_err, d.pls, d.rd, d.tmo);
        end
      end
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_drain(input int unsigned lim, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      cyc(1);
      if (exp_ch.size() == 0 && exp_done.size() == 0 && busy === 1'b0 && req == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({done_pls, rd_data, tmo_err, busy, a2d.strt_cnv, a2d.chnnl, scan_vld} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pls=%b rd=%h tmo=%b busy=%b strt=%b ch=%0d vld=%h expected all 0",
               done_pls, rd_data, tmo_err, busy, a2d.strt_cnv, a2d.chnnl, scan_vld);
    end
    checks++;
    if (scan_res !== '0) begin
      errors++;
      $display("FAIL reset_scan_res got %h expected 0", scan_res);
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_single;
    int dcyc;
    lat = 20;
    fixed_res = 1'b1;
    req_chnnl[5:3] = 3'd5;
    exp_ch.push_back(3'd5);
    exp_done.push_back('{pls: 4'b0010, rd: 12'hA5C, tmo: 1'b0, rd_chk: 1'b1});
    req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (a2d.strt_cnv !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_grant_cycle got strt=%b busy=%b expected 0 0", a2d.strt_cnv, busy);
    end
    @(negedge clk);
    checks++;
    if (a2d.strt_cnv !== 1'b1 || a2d.chnnl !== 3'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_strt got strt=%b ch=%0d busy=%b expected 1 5 1", a2d.strt_cnv, a2d.chnnl, busy);
    end
    dcyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done_pls[1] === 1'b1 && dcyc < 0) dcyc = k;
    end
    checks++;
    if (dcyc != 21) begin
      errors++;
      $display("FAIL single_latency got done at strt+%0d expected strt+21", dcyc);
    end
    checks++;
    if (busy !== 1'b0 || rd_data !== 12'hA5C || exp_done.size() != 0) begin
      errors++;
      $display("FAIL single_after got busy=%b rd=%h pending=%0d expected 0 a5c 0", busy, rd_data, exp_done.size());
    end
    cyc(1);
  endtask

  task automatic test_round_robin;
    bit ok;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    lat = 5;
    fixed_res = 1'b0;
    req_chnnl = {3'd4, 3'd3, 3'd2, 3'd1};
    exp_ch.push_back(3'd1);
    exp_ch.push_back(3'd3);
    exp_done.push_back('{pls: 4'b0001, rd: 12'h010, tmo: 1'b0, rd_chk: 1'b1});
    exp_done.push_back('{pls: 4'b0100, rd: 12'h030, tmo: 1'b0, rd_chk: 1'b1});
    req = 4'b0101;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_pair_drain got timeout expected drained"); end
    exp_ch.push_back(3'd4);
    exp_ch.push_back(3'd1);
    exp_ch.push_back(3'd3);
    exp_done.push_back('{pls: 4'b1000, rd: 12'h040, tmo: 1'b0, rd_chk: 1'b1});
    exp_done.push_back('{pls: 4'b0001, rd: 12'h010, tmo: 1'b0, rd_chk: 1'b1});
    exp_done.push_back('{pls: 4'b0100, rd: 12'h030, tmo: 1'b0, rd_chk: 1'b1});
    req = 4'b1101;
    wait_drain(150, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_triple_drain got timeout expected drained"); end
  endtask

  task automatic test_timeout;
    bit ok;
    lat = 0;
    req_chnnl[8:6] = 3'd6;
    exp_ch.push_back(3'd6);
    exp_done.push_back('{pls: 4'b0100, rd: 12'hFFF, tmo: 1'b1, rd_chk: 1'b1});
    req = 4'b0100;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_abort_drain got timeout expected idle"); end
    lat = int'(TC);
    exp_ch.push_back(3'd6);
    exp_done.push_back('{pls: 4'b0100, rd: 12'h060, tmo: 1'b0, rd_chk: 1'b1});
    req = 4'b0100;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_terminal_drain got timeout expected idle"); end
  endtask

  task automatic test_scan;
    bit ok;
    logic [95:0] exp_res;
    lat = 3;
    fixed_res = 1'b0;
    strt_t.delete();
    exp_ch.push_back(3'd0);
    exp_ch.push_back(3'd2);
    exp_ch.push_back(3'd7);
    exp_ch.push_back(3'd0);
    scan_mask = 8'b1000_0101;
    scan_en = 1'b1;
    wait_drain(200, ok);
    scan_mask = 8'h00;
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_drain got timeout expected four scans"); end
    checks++;
    if (strt_t.size() != 4 || strt_t[1] - strt_t[0] != 10 * SD || strt_t[2] - strt_t[1] != 10 * SD) begin
      errors++;
      $display("FAIL scan_slot_gap got n=%0d gaps %0d %0d expected 4 %0d %0d", strt_t.size(),
               strt_t[1] - strt_t[0], strt_t[2] - strt_t[1], 10 * SD, 10 * SD);
    end
    exp_res = '0;
    exp_res[24 +: 12] = 12'h020;
    exp_res[84 +: 12] = 12'h070;
    checks++;
    if (scan_res !== exp_res || scan_vld !== 8'h85) begin
      errors++;
      $display("FAIL scan_holding got res=%h vld=%h expected res=%h vld=85", scan_res, scan_vld, exp_res);
    end
  endtask

  task automatic test_mask_zero;
    int n0;
    n0 = n_strt;
    cyc(60);
    checks++;
    if (n_strt != n0) begin
      errors++;
      $display("FAIL mask_zero_idle got %0d strt_cnv expected 0", n_strt - n0);
    end
  endtask

  task automatic test_priority;
    bit ok;
    int n0;
    req_chnnl[5:3] = 3'd3;
    exp_ch.push_back(3'd3);
    exp_ch.push_back(3'd1);
    exp_done.push_back('{pls: 4'b0010, rd: 12'h030, tmo: 1'b0, rd_chk: 1'b1});
    req = 4'b0010;
    scan_mask = 8'h02;
    scan_en = 1'b0;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL prio_drain got timeout expected idle"); end
    n0 = n_strt;
    cyc(40);
    checks++;
    if (n_strt != n0) begin
      errors++;
      $display("FAIL prio_no_stack got %0d extra strt_cnv expected 0", n_strt - n0);
    end
    checks++;
    if (scan_vld !== 8'h87 || scan_res[12 +: 12] !== 12'h010) begin
      errors++;
      $display("FAIL prio_scan_res got vld=%h res1=%h expected 87 010", scan_vld, scan_res[12 +: 12]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n0;
    scan_mask = 8'h00;
    lat = 20;
    req_chnnl[5:3] = 3'd5;
    req_chnnl[11:9] = 3'd2;
    exp_ch.push_back(3'd5);
    req = 4'b0010;
    for (int unsigned i = 0; i < 20 && exp_ch.size() != 0; i++) cyc(1);
    cyc(5);
    checks++;
    if (busy !== 1'b1 || exp_ch.size() != 0) begin
      errors++;
      $display("FAIL rstmid_in_wait got busy=%b pending=%0d expected 1 0", busy, exp_ch.size());
    end
    rst = 1'b1;
    req = '0;
    cyc(1);
    rst = 1'b0;
    checks++;
    if ({done_pls, rd_data, tmo_err, busy, a2d.strt_cnv, a2d.chnnl, scan_vld} !== '0 || scan_res !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got pls=%b rd=%h tmo=%b busy=%b strt=%b ch=%0d vld=%h expected all 0",
               done_pls, rd_data, tmo_err, busy, a2d.strt_cnv, a2d.chnnl, scan_vld);
    end
    n0 = n_strt;
    cyc(25);
    checks++;
    if (n_strt != n0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_late_cmplt got strt=%0d busy=%b expected 0 0", n_strt - n0, busy);
    end
    exp_ch.push_back(3'd5);
    exp_ch.push_back(3'd2);
    exp_done.push_back('{pls: 4'b0010, rd: 12'h050, tmo: 1'b0, rd_chk: 1'b1});
    exp_done.push_back('{pls: 4'b1000, rd: 12'h020, tmo: 1'b0, rd_chk: 1'b1});
    req = 4'b1010;
    wait_drain(150, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_resume got timeout expected drained"); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_scan();
    test_mask_zero();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
